// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser.
// Optional feature macro used by this block: LED_CHASER_BOUNCE_EN (ping-pong at the ends).
package led_chaser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;  // shift toward MSB
    localparam logic DIR_DOWN = 1'b1;  // shift toward LSB

endpackage

// File: rtl/toggle_edge_sync.sv
// Brings a slow asynchronous toggle into the clk domain and emits a one-cycle
// step for every transition (rising or falling) of the toggle.
module toggle_edge_sync
    import led_chaser_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_toggle,
    output logic step
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Two flops for metastability, the third remembers the previous settled value.
    always_comb begin
        s1_d = in_toggle;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer chain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign step = s2_q ^ s3_q;

endmodule

// File: rtl/led_chaser.sv
// One-hot LED chaser advanced by toggles of a slow input, with a small
// IDLE/RUN/PAUSE controller and an optional bounded run length.
// Optional feature macro: LED_CHASER_BOUNCE_EN -- reverse at the end bits
// instead of wrapping around.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int N_LED     = 8,
    parameter int RUN_STEPS = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_toggle,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0] RUN_STEPS_C = CNT_W'(RUN_STEPS);
    localparam logic [N_LED-1:0] LED_LSB     = N_LED'(1);
    localparam logic [N_LED-1:0] LED_MSB     = {1'b1, {(N_LED-1){1'b0}}};

    logic step;

    state_t           state_q, state_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N_LED-1:0] led_step;
    logic             dir_step;
    logic [CNT_W-1:0] cnt_inc;

    toggle_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_toggle (in_toggle),
        .step      (step)
    );

    // Pattern one position further along the current direction.
    always_comb begin
        led_step = led_q;
        dir_step = dir_q;
`ifdef LED_CHASER_BOUNCE_EN
        if (dir_q == DIR_UP) begin
            if (led_q[N_LED-1]) begin
                led_step = led_q >> 1;
                dir_step = DIR_DOWN;
            end else begin
                led_step = led_q << 1;
            end
        end else begin
            if (led_q[0]) begin
                led_step = led_q << 1;
                dir_step = DIR_UP;
            end else begin
                led_step = led_q >> 1;
            end
        end
`else
        if (dir_q == DIR_UP) begin
            led_step = {led_q[N_LED-2:0], led_q[N_LED-1]};
        end else begin
            led_step = {led_q[0], led_q[N_LED-1:1]};
        end
`endif
    end

    assign cnt_inc = step_cnt_q + CNT_W'(1);

    // Controller: stop wins, then pause, then step; start only from IDLE.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        step_cnt_d = step_cnt_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                led_d = '0;
                if (start && !stop) begin
                    state_d    = RUN;
                    dir_d      = dir;
                    led_d      = (dir == DIR_DOWN) ? LED_MSB : LED_LSB;
                    step_cnt_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d    = IDLE;
                    led_d      = '0;
                    step_cnt_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (step) begin
                    if ((RUN_STEPS != 0) && (cnt_inc == RUN_STEPS_C)) begin
                        state_d    = IDLE;
                        led_d      = '0;
                        step_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        led_d      = led_step;
                        dir_d      = dir_step;
                        step_cnt_d = cnt_inc;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d    = IDLE;
                    led_d      = '0;
                    step_cnt_d = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = IDLE;
                led_d      = '0;
                step_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Controller, pattern, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            led_q      <= '0;
            step_cnt_q <= '0;
            dir_q      <= DIR_UP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            step_cnt_q <= step_cnt_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: a bounded-run instance (RUN_STEPS=16) and a
// free-running instance (RUN_STEPS=0) share the same stimulus.
module tb_led_chaser;

    logic       clk;
    logic       rst_n;
    logic       in_toggle;
    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    logic [7:0] led, led0;
    logic       busy, busy0;
    logic       done, done0;
    logic [7:0] step_cnt, step_cnt0;

    int n_cmp  = 0;
    int n_fail = 0;
    int done0_pulses = 0;
    int snap;

    logic [7:0] m_led;
    logic       m_dir;
    logic [7:0] exp_led;

    led_chaser #(.N_LED(8), .RUN_STEPS(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_toggle(in_toggle), .start(start),
        .stop(stop), .pause(pause), .dir(dir), .led(led), .busy(busy),
        .done(done), .step_cnt(step_cnt)
    );

    led_chaser #(.N_LED(8), .RUN_STEPS(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_toggle(in_toggle), .start(start),
        .stop(stop), .pause(pause), .dir(dir), .led(led0), .busy(busy0),
        .done(done0), .step_cnt(step_cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (done0) done0_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Toggle, then let the change settle in the pattern (3 edges), then idle out the 20-clk slot.
    task automatic do_step();
        in_toggle = ~in_toggle;
        tick(3);
    endtask

    // Reference next pattern for the 8-LED chaser.
    task automatic mstep();
`ifdef LED_CHASER_BOUNCE_EN
        if (m_dir == 1'b0) begin
            if (m_led[7]) begin m_led = m_led >> 1; m_dir = 1'b1; end
            else m_led = m_led << 1;
        end else begin
            if (m_led[0]) begin m_led = m_led << 1; m_dir = 1'b0; end
            else m_led = m_led >> 1;
        end
`else
        if (m_dir == 1'b0) m_led = {m_led[6:0], m_led[7]};
        else               m_led = {m_led[0], m_led[7:1]};
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_toggle = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;

        // Reset held with the toggle moving
        tick(2); in_toggle = 1'b1; tick(3); in_toggle = 1'b0; tick(3);
        chk("rst_led", led, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", step_cnt, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin do_step(); tick(17); end
        chk("idle_led", led, 8'h00);
        chk("idle_busy", busy, 1'b0);

        // Normal 16-step run upward
        dir = 1'b0; start = 1'b1; tick(1); start = 1'b0;
        m_led = 8'h01; m_dir = 1'b0;
        chk("run_start_led", led, 8'h01);
        chk("run_start_busy", busy, 1'b1);
        chk("run_start_cnt", step_cnt, 8'd0);
        in_toggle = ~in_toggle; tick(2);
        chk("latency_early", led, 8'h01);
        tick(1); mstep();
        chk("latency_led", led, m_led);
        chk("latency_cnt", step_cnt, 8'd1);
        tick(17);
        for (int k = 2; k <= 16; k++) begin
            do_step();
            if (k < 16) begin
                mstep();
                chk("run_led", led, m_led);
                chk("run_cnt", step_cnt, k);
            end else begin
                chk("end_led", led, 8'h00);
                chk("end_done", done, 1'b1);
                chk("end_busy", busy, 1'b0);
                chk("end_cnt", step_cnt, 8'd0);
                tick(1);
                chk("end_done_1cyc", done, 1'b0);
            end
            tick(16);
        end

        // Pause after step 3
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 3; i++) begin do_step(); tick(17); end
        chk("pre_pause_led", led, 8'h08);
        chk("pre_pause_cnt", step_cnt, 8'd3);
        pause = 1'b1; tick(1);
        for (int i = 0; i < 4; i++) begin do_step(); tick(17); end
        chk("paused_led", led, 8'h08);
        chk("paused_cnt", step_cnt, 8'd3);
        chk("paused_busy", busy, 1'b1);
        pause = 1'b0; tick(1);
        do_step();
        chk("resume_led", led, 8'h10);
        chk("resume_cnt", step_cnt, 8'd4);
        tick(17);

        // Stop coinciding with a step at 0x04
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("stop_led", led, 8'h00);
        chk("stop_busy", busy, 1'b0);
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 2; i++) begin do_step(); tick(17); end
        chk("pre_stop_led", led, 8'h04);
        in_toggle = ~in_toggle; tick(2);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("stopstep_led", led, 8'h00);
        chk("stopstep_busy", busy, 1'b0);
        chk("stopstep_done", done, 1'b0);
        chk("stopstep_cnt", step_cnt, 8'd0);
        tick(1);
        chk("stopstep_done2", done, 1'b0);
        tick(17);
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 1'b0);
        chk("startstop_led", led, 8'h00);

        // Downward run from 0x80, dir changed mid-run must be ignored
        dir = 1'b1; start = 1'b1; tick(1); start = 1'b0; dir = 1'b0;
        chk("down_start_led", led, 8'h80);
        for (int k = 1; k <= 8; k++) begin
            do_step();
            if (k < 8) exp_led = 8'h80 >> k;
`ifdef LED_CHASER_BOUNCE_EN
            else exp_led = 8'h02;
`else
            else exp_led = 8'h80;
`endif
            chk("down_led", led, exp_led);
            chk("down_cnt", step_cnt, k);
            tick(17);
        end
        stop = 1'b1; tick(1); stop = 1'b0;

        // Asynchronous reset mid-run at 0x20
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 5; i++) begin do_step(); tick(17); end
        chk("pre_arst_led", led, 8'h20);
        in_toggle = ~in_toggle; tick(1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cnt", step_cnt, 8'd0);
        chk("arst_busy0", busy0, 1'b0);
        tick(1); rst_n = 1'b1;
        tick(20);
        chk("post_arst_led", led, 8'h00);
        chk("post_arst_busy", busy, 1'b0);

        // Unbounded instance: 300 steps, no done, count wraps to 44
        snap = done0_pulses;
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_toggle = ~in_toggle;
            tick(4);
        end
        tick(5);
        chk("free_cnt", step_cnt0, 8'd44);
        chk("free_done", done0_pulses - snap, 0);
        chk("free_busy", busy0, 1'b1);
`ifdef LED_CHASER_BOUNCE_EN
        chk("free_led", led0, 8'h40);
`else
        chk("free_led", led0, 8'h10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
